shift_frame_ctrl: RTL and testbench
===================================

# shift_frame_ctrl

Frame controller that shares one serial-in/parallel-out shift register between two requesters. It accepts parallel words through a valid/ready handshake and arbitrates round-robin between the requesters. For each accepted word it clears the shift register, then drives the word onto the register's serial input MSB-first, one bit per clock with a shift enable. It sits directly in front of the shift register and is that register's only source of `serial_in`.

## Interface
- `WIDTH`, 4: word width; equals the shift register depth. Minimum 2.
- `GAP`, 1: idle cycles inserted after each frame. 0 is allowed.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. 0 resets all state immediately.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  WIDTH  requester 0 word.
- `req0_ready`  out  1  requester 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `sr_clear`  out  1  synchronous clear strobe to the shift register.
- `sr_shift_en`  out  1  shift strobe; the register shifts `sr_serial_in` in when high.
- `sr_serial_in`  out  1  serial data bit to the register.
- `frame_done`  out  1  one-cycle pulse; the last bit of a frame has been shifted in.
- `busy`  out  1  high whenever state is not IDLE.
- `grant_id`  out  1  id of the most recently accepted requester.

## Operation
- States: IDLE, CLEAR, SHIFT, GAP. Reset state is IDLE.
- Reset values:
  - all outputs 0
  - bit counter 0
  - round-robin pointer `last` = 1, so requester 0 wins the first tie
- **IDLE**
  - `reqN_ready` is combinational and is high only for the arbitration winner.
  - Winner when only one `valid` is high: that requester.
  - Winner when both are high: the requester that is not `last`.
  - Handshake: `valid & ready` in the same cycle.
  - On handshake: latch the data word, set `grant_id` and `last` to the winner, go to CLEAR.
  - With no valid request, stay in IDLE.
- **CLEAR**
  - One cycle with `sr_clear` = 1.
  - Next state is SHIFT with counter = 0.
- **SHIFT**
  - Lasts exactly WIDTH cycles with `sr_shift_en` = 1.
  - `sr_serial_in` = latched word bit [WIDTH-1-counter]; counter increments each cycle.
  - After the counter reaches WIDTH-1, go to GAP if GAP > 0, otherwise to IDLE.
- **GAP**
  - Lasts GAP cycles with all `sr_*` outputs = 0, then IDLE.
- `frame_done` is 1 for exactly the first cycle after the final SHIFT cycle. That cycle is the first GAP cycle, or the IDLE cycle when GAP = 0.
- Both `ready` outputs are 0 outside IDLE. `valid` and `data` changes during a frame are ignored. A requester holding `valid` is served when the controller returns to IDLE.
- `sr_serial_in` is 0 whenever `sr_shift_en` = 0.
- Counter width is `$clog2(WIDTH)`. The counter does not wrap past WIDTH-1 within a frame.

## Timing
- Handshake in cycle T:
  - `sr_clear` in T+1
  - shifts in T+2 .. T+1+WIDTH
  - `frame_done` in T+2+WIDTH
- Earliest next handshake is T+2+WIDTH+GAP. Throughput is one frame per WIDTH+2+GAP cycles.
- Once the register has seen all WIDTH shift strobes, its parallel output equals the accepted word. With shift direction toward the MSB, the first bit sent ends up as the MSB.
- Back-to-back frames: when GAP = 0, the IDLE cycle that carries `frame_done` may also accept the next word.
- Reset mid-frame:
  - all outputs drop to 0 asynchronously
  - the frame is abandoned with no `frame_done`
  - `last` returns to 1
- Simultaneous valid on both requesters in IDLE: exactly one `ready`, never both.
- Every output except `reqN_ready` is registered.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with both `valid` = 1 -> both `ready` = 0, all `sr_*` = 0, `busy` = 0, `grant_id` = 0. Assert `reset` = 0 asynchronously between edges mid-SHIFT -> outputs 0 before the next edge.
- **Single frame:** WIDTH = 4, GAP = 1, `req0` sends 4'b1011 -> `sr_clear` one cycle, then `sr_serial_in` = 1, 0, 1, 1 with `sr_shift_en` high, then `frame_done` pulse. Register `parallel_out` = 1011, `busy` low 2 cycles after the last shift.
- **Tie and round-robin:** both valid from reset with `req0` = 4'b0110, `req1` = 4'b1001 -> `req0` is accepted first (`grant_id` = 0), `req1` next (`grant_id` = 1). With both held valid, grants alternate 0, 1, 0, 1 over 4 frames with handshakes 7 cycles apart.
- **Data change mid-frame:** change `req1_data` from 4'b1100 to 4'b0011 during SHIFT -> the serialized bits remain 1, 1, 0, 0.
- **Reset mid-frame:** assert reset after 2 shift cycles of 4'b1111, then release -> no `frame_done`. The next handshake starts a fresh frame with `sr_clear`.
- **GAP = 0 back-to-back:** `req0` continuously valid -> handshakes 6 cycles apart, and `frame_done` coincides with the next `req0_ready`.

Source files
------------

// File: rtl/shift_frame_ctrl.sv
// Round-robin frame controller feeding a shared SIPO shift register.
// Each accepted word becomes a clear strobe, WIDTH MSB-first shift cycles and an optional idle gap.
module shift_frame_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sr_clear,
  output logic             sr_shift_en,
  output logic             sr_serial_in,
  output logic             frame_done,
  output logic             busy,
  output logic             grant_id
);

  localparam int unsigned CW       = $clog2(WIDTH);
  localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_M1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic             clr_q, shift_q, ser_q, done_q, busy_q;
  logic             win0, win1;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    win0       = req0_valid & (~req1_valid | last_q);
    win1       = req1_valid & (~req0_valid | ~last_q);
    // Gated by reset so neither requester sees ready while the block is held in reset.
    req0_ready = reset & (state_q == S_IDLE) & win0;
    req1_ready = reset & (state_q == S_IDLE) & win1;

    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    word_d  = word_q;
    last_d  = last_q;
    grant_d = grant_q;

    case (state_q)
      S_IDLE: begin
        if (req0_ready | req1_ready) begin
          word_d  = req1_ready ? req1_data : req0_data;
          grant_d = req1_ready;
          last_d  = req1_ready;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          gap_d   = '0;
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    shifted = word_d << cnt_d;
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      clr_q   <= 1'b0;
      shift_q <= 1'b0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      clr_q   <= (state_d == S_CLEAR);
      shift_q <= (state_d == S_SHIFT);
      ser_q   <= (state_d == S_SHIFT) & shifted[WIDTH-1];
      done_q  <= (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign sr_clear     = clr_q;
  assign sr_shift_en  = shift_q;
  assign sr_serial_in = ser_q;
  assign frame_done   = done_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Bench for shift_frame_ctrl: directed scenarios plus random traffic against a frame-timeline model.
// Instance 0 uses GAP=1, instance 1 uses GAP=0; both see the same requester stimulus.
module tb_shift_frame_ctrl;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic [1:0] rdy0, rdy1, clr, sh, ser, done, busy, gid;
  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_frame_ctrl #(.WIDTH(W), .GAP(1)) dut_g1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(rdy0[0]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(rdy1[0]),
    .sr_clear(clr[0]), .sr_shift_en(sh[0]), .sr_serial_in(ser[0]),
    .frame_done(done[0]), .busy(busy[0]), .grant_id(gid[0])
  );

  shift_frame_ctrl #(.WIDTH(W), .GAP(0)) dut_g0 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(rdy0[1]),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(rdy1[1]),
    .sr_clear(clr[1]), .sr_shift_en(sh[1]), .sr_serial_in(ser[1]),
    .frame_done(done[1]), .busy(busy[1]), .grant_id(gid[1])
  );

  // Downstream shift register, shifting toward the MSB.
  logic [W-1:0] sreg [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr[i])     sreg[i] <= '0;
      else if (sh[i]) sreg[i] <= {sreg[i][W-2:0], ser[i]};
    end
  end

  // Reference model: frame timeline as an offset k from the handshake cycle.
  bit           m_has   [2];
  int unsigned  m_k     [2];
  logic [W-1:0] m_word  [2];
  bit           m_grant [2];
  bit           m_last  [2];

  function automatic int unsigned gapv(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit m_idle(int i);
    return !m_has[i] || (m_k[i] >= W + 2 + gapv(i));
  endfunction

  function automatic int m_win(int i);
    if (req0_valid && req1_valid) return m_last[i] ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_has[i] <= 0; m_k[i] <= 0; m_word[i] <= '0; m_grant[i] <= 0; m_last[i] <= 1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_idle(i) && m_win(i) >= 0) begin
          m_has[i]   <= 1;
          m_k[i]     <= 1;
          m_word[i]  <= (m_win(i) == 1) ? req1_data : req0_data;
          m_grant[i] <= (m_win(i) == 1);
          m_last[i]  <= (m_win(i) == 1);
        end else if (m_has[i] && m_k[i] < 100) begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  function automatic logic [7:0] m_expect(int i);
    bit e_r0, e_r1, e_clr, e_sh, e_ser, e_done, e_busy;
    int idx;
    e_r0   = (reset === 1'b1) && m_idle(i) && (m_win(i) == 0);
    e_r1   = (reset === 1'b1) && m_idle(i) && (m_win(i) == 1);
    e_clr  = m_has[i] && (m_k[i] == 1);
    e_sh   = m_has[i] && (m_k[i] >= 2) && (m_k[i] <= W + 1);
    idx    = int'(W) + 1 - int'(m_k[i]);
    e_ser  = e_sh && m_word[i][idx];
    e_done = m_has[i] && (m_k[i] == W + 2);
    e_busy = m_has[i] && (m_k[i] >= 1) && (m_k[i] <= W + 1 + gapv(i));
    return {e_r0, e_r1, e_clr, e_sh, e_ser, e_done, e_busy, m_grant[i]};
  endfunction

  task automatic do_reset();
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = W'($urandom); req1_data = W'($urandom);
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({rdy0, rdy1, clr, sh, ser, done, busy, gid} !== 16'h0) begin
        fails++;
        $display("FAIL reset_outputs: got %b expected all 0", {rdy0, rdy1, clr, sh, ser, done, busy, gid});
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [W-1:0] exp_bits;
    exp_bits = 4'b1011;
    do_reset();
    req0_data = exp_bits; req0_valid = 1'b1; req1_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({rdy0[0], rdy1[0]} !== 2'b10) begin
      fails++; $display("FAIL single_ready: got %b expected 10", {rdy0[0], rdy1[0]});
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({clr[0], sh[0], busy[0]} !== 3'b101) begin
      fails++; $display("FAIL single_clear: got clr/sh/busy=%b expected 101", {clr[0], sh[0], busy[0]});
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      tests++;
      if ({clr[0], sh[0], ser[0]} !== {1'b0, 1'b1, exp_bits[3-b]}) begin
        fails++;
        $display("FAIL single_bit%0d: got clr/sh/ser=%b expected 01%b", b, {clr[0], sh[0], ser[0]}, exp_bits[3-b]);
      end
    end
    @(negedge clk);
    tests++;
    if ({done[0], busy[0], sh[0], ser[0]} !== 4'b1100) begin
      fails++; $display("FAIL single_done: got done/busy/sh/ser=%b expected 1100", {done[0], busy[0], sh[0], ser[0]});
    end
    tests++;
    if (sreg[0] !== exp_bits) begin
      fails++; $display("FAIL single_parallel: got %b expected %b", sreg[0], exp_bits);
    end
    @(negedge clk);
    tests++;
    if ({done[0], busy[0]} !== 2'b00) begin
      fails++; $display("FAIL single_idle: got done/busy=%b expected 00", {done[0], busy[0]});
    end
  endtask

  task automatic test_round_robin();
    int nh = 0;
    int unsigned prev_cyc = 0;
    bit cur_win = 0;
    logic [W-1:0] d0, d1;
    d0 = 4'b0110; d1 = 4'b1001;
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = d0; req1_data = d1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    for (int n = 0; n < 40 && nh < 4; n++) begin
      @(negedge clk);
      if (done[0]) begin
        tests++;
        if (gid[0] !== cur_win || sreg[0] !== (cur_win ? d1 : d0)) begin
          fails++;
          $display("FAIL rr_frame%0d: got grant=%b word=%b expected grant=%b word=%b",
                   nh, gid[0], sreg[0], cur_win, cur_win ? d1 : d0);
        end
      end
      if (rdy0[0] || rdy1[0]) begin
        tests++;
        if ({rdy0[0], rdy1[0]} !== ((nh % 2 == 0) ? 2'b10 : 2'b01)) begin
          fails++;
          $display("FAIL rr_grant%0d: got ready0/1=%b expected %b", nh, {rdy0[0], rdy1[0]},
                   (nh % 2 == 0) ? 2'b10 : 2'b01);
        end
        if (nh > 0) begin
          tests++;
          if (cyc - prev_cyc != 7) begin
            fails++; $display("FAIL rr_spacing%0d: got %0d expected 7", nh, cyc - prev_cyc);
          end
        end
        cur_win = rdy1[0];
        prev_cyc = cyc;
        nh++;
      end
    end
    tests++;
    if (nh != 4) begin
      fails++; $display("FAIL rr_count: got %0d handshakes expected 4", nh);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_data_change();
    logic [W-1:0] bits = '0;
    int nb = 0;
    bit hs = 0;
    do_reset();
    req1_data = 4'b1100; req1_valid = 1'b1; req0_valid = 1'b0;
    for (int n = 0; n < 5 && !hs; n++) begin
      @(negedge clk);
      if (rdy1[0]) hs = 1;
      @(posedge clk); #1;
    end
    tests++;
    if (!hs) begin
      fails++; $display("FAIL chg_handshake: got no ready1 expected ready1 within 5 cycles");
    end
    req1_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (sh[0]) begin
        bits = {bits[W-2:0], ser[0]};
        nb++;
      end
      @(posedge clk); #1;
      if (nb == 1) req1_data = 4'b0011;
    end
    tests++;
    if (bits !== 4'b1100 || nb != 4) begin
      fails++; $display("FAIL chg_bits: got %b (%0d shifts) expected 1100 (4 shifts)", bits, nb);
    end
  endtask

  task automatic test_reset_mid();
    int nsh = 0;
    do_reset();
    req0_data = 4'b1111; req0_valid = 1'b1; req1_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (rdy0[0] !== 1'b1) begin
      fails++; $display("FAIL mid_ready: got %b expected 1", rdy0[0]);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    for (int n = 0; n < 6 && nsh < 2; n++) begin
      @(negedge clk);
      if (sh[0]) nsh++;
    end
    @(posedge clk); #2 reset = 1'b0;
    #1;
    tests++;
    if ({clr, sh, ser, done, busy, gid} !== 12'h0) begin
      fails++; $display("FAIL mid_async: got %b expected all 0", {clr, sh, ser, done, busy, gid});
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      tests++;
      if (done !== 2'b00 || busy !== 2'b00) begin
        fails++; $display("FAIL mid_no_done: got done=%b busy=%b expected 00 00", done, busy);
      end
    end
    @(posedge clk); #1 req0_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (rdy0[0] !== 1'b1) begin
      fails++; $display("FAIL mid_rehandshake: got %b expected 1", rdy0[0]);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({clr[0], sh[0]} !== 2'b10) begin
      fails++; $display("FAIL mid_fresh_clear: got clr/sh=%b expected 10", {clr[0], sh[0]});
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int nh = 0;
    int unsigned prev_cyc = 0;
    do_reset();
    req0_data = W'($urandom); req0_valid = 1'b1; req1_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rdy0[1]) begin
        if (nh > 0) begin
          tests++;
          if (cyc - prev_cyc != 6 || done[1] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_hs%0d: got spacing=%0d done=%b expected 6 1", nh, cyc - prev_cyc, done[1]);
          end
        end
        prev_cyc = cyc;
        nh++;
      end else if (done[1]) begin
        tests++; fails++;
        $display("FAIL b2b_done_alone: got done=1 ready0=0 expected ready0=1 with done");
      end
    end
    tests++;
    if (nh < 4) begin
      fails++; $display("FAIL b2b_count: got %0d handshakes expected >=4", nh);
    end
    @(posedge clk); #1 req0_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] e, a;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_data  = W'($urandom);
      req1_data  = W'($urandom);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        e = m_expect(i);
        a = {rdy0[i], rdy1[i], clr[i], sh[i], ser[i], done[i], busy[i], gid[i]};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL rand_inst%0d_cyc%0d: got r0,r1,clr,sh,ser,done,busy,gid=%b expected %b", i, n, a, e);
        end
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_data_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
